// File: rtl/scan_pkg.sv
// Shared constants and helpers for the display digit scan counter.
package scan_pkg;

    localparam int unsigned DEF_DIGITS       = 4;
    localparam int unsigned DEF_PRESCALE     = 16;
    localparam int unsigned DEF_BLANK_CYCLES = 2;
    localparam int unsigned MAX_DIGITS       = 64;

    // One-hot anode pattern for digit idx; callers truncate to their digit count.
    function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx);
        return MAX_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running clock divider producing a one-cycle step at terminal count.
module scan_prescaler #(
    parameter int unsigned PRESCALE = scan_pkg::DEF_PRESCALE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] cnt;
    logic          terminal;

    assign terminal = (cnt == PW'(PRESCALE - 1));
    assign step     = en && !clr && terminal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= terminal ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/digit_scan_counter.sv
// Digit-select scan counter for a multiplexed 7-segment display.
// Optional anode blanking after each step is enabled by defining SCAN_BLANK_EN.
module digit_scan_counter
    import scan_pkg::*;
#(
    parameter  int unsigned DIGITS       = DEF_DIGITS,
    parameter  int unsigned PRESCALE     = DEF_PRESCALE,
    parameter  int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES,
    localparam int unsigned CW           = $clog2(DIGITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up,
    input  logic              clr,
    output logic [CW-1:0]     r,
    output logic [DIGITS-1:0] an,
    output logic              tick,
    output logic              wrap
);

    if (DIGITS < 2 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("digit_scan_counter: DIGITS out of range");
    end
    if (PRESCALE < 1 || BLANK_CYCLES >= PRESCALE) begin : g_bad_timing
        $error("digit_scan_counter: need PRESCALE >= 1 and BLANK_CYCLES < PRESCALE");
    end

    logic              step;
    logic [CW-1:0]     r_q;
    logic [CW-1:0]     r_nxt;
    logic              wrap_c;
    logic              tick_q;
    logic              wrap_q;
    logic [DIGITS-1:0] an_oh;

    scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .step  (step)
    );

    // Next digit index with explicit wrap at DIGITS-1 so r never leaves 0..DIGITS-1.
    always_comb begin
        r_nxt  = r_q;
        wrap_c = 1'b0;
        if (up) begin
            wrap_c = (r_q == CW'(DIGITS - 1));
            r_nxt  = wrap_c ? '0 : r_q + CW'(1);
        end else begin
            wrap_c = (r_q == '0);
            r_nxt  = wrap_c ? CW'(DIGITS - 1) : r_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else if (clr) begin
            r_q    <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            tick_q <= step;
            wrap_q <= step && wrap_c;
            if (step) begin
                r_q <= r_nxt;
            end
        end
    end

    assign an_oh = DIGITS'(onehot(32'(r_q)));
    assign r     = r_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;

`ifdef SCAN_BLANK_EN
    localparam int unsigned BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    logic [BW-1:0] blank_q;

    // Remaining anode-off cycles; loaded on each step, counts only while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else if (clr) begin
            blank_q <= '0;
        end else if (step) begin
            blank_q <= BW'(BLANK_CYCLES);
        end else if (en && (blank_q != '0)) begin
            blank_q <= blank_q - BW'(1);
        end
    end

    assign an = (blank_q != '0) ? '0 : an_oh;
`else
    assign an = an_oh;
`endif

endmodule

// File: tb/tb_digit_scan_counter.sv
// Self-checking bench for digit_scan_counter: two instances (4 and 3 digits)
// against an arithmetic reference model, plus directed literal checks.
module tb_digit_scan_counter;

    localparam int BLANK = 2;
`ifdef SCAN_BLANK_EN
    localparam int BLK_ON = 1;
`else
    localparam int BLK_ON = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic up    = 1'b1;
    logic clr   = 1'b0;

    always #5 clk = ~clk;

    logic [1:0] r4, r3;
    logic [3:0] an4;
    logic [2:0] an3;
    logic       t4, w4, t3, w3;

    digit_scan_counter #(.DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(BLANK)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr),
        .r(r4), .an(an4), .tick(t4), .wrap(w4)
    );

    digit_scan_counter #(.DIGITS(3), .PRESCALE(5), .BLANK_CYCLES(BLANK)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr),
        .r(r3), .an(an3), .tick(t3), .wrap(w3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: elapsed enabled cycles per period, digit index mod DIGITS.
    int dg[2] = '{4, 3};
    int ps[2] = '{4, 5};
    int ph[2], mr[2], mb[2];
    bit mt[2], mw[2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n || clr) begin
                ph[i] = 0; mr[i] = 0; mt[i] = 0; mw[i] = 0; mb[i] = 0;
            end else if (en) begin
                ph[i] = ph[i] + 1;
                if (ph[i] == ps[i]) begin
                    ph[i] = 0;
                    mr[i] = up ? (mr[i] + 1) % dg[i] : (mr[i] + dg[i] - 1) % dg[i];
                    mt[i] = 1;
                    mw[i] = up ? (mr[i] == 0) : (mr[i] == dg[i] - 1);
                    mb[i] = BLANK;
                end else begin
                    mt[i] = 0;
                    mw[i] = 0;
                    if (mb[i] > 0) mb[i] = mb[i] - 1;
                end
            end else begin
                mt[i] = 0;
                mw[i] = 0;
            end
        end
    end

    function automatic int exp_an(input int i);
        if (BLK_ON != 0 && mb[i] > 0) return 0;
        return 1 << mr[i];
    endfunction

    always @(negedge clk) begin
        chk("m4_r",    r4,  mr[0]);
        chk("m4_an",   an4, exp_an(0));
        chk("m4_tick", t4,  mt[0]);
        chk("m4_wrap", w4,  mw[0]);
        chk("m3_r",    r3,  mr[1]);
        chk("m3_an",   an3, exp_an(1));
        chk("m3_tick", t3,  mt[1]);
        chk("m3_wrap", w3,  mw[1]);
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; up = 1'b1;
        edges(2);
        chk("rst_r4", r4, 0);
        chk("rst_an4", an4, 1);
        chk("rst_t4", t4, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        edges(1);
        // Up scan from reset, PRESCALE=4.
        do_reset();
        en = 1'b1;
        edges(3);  chk("t1_pre_tick", t4, 0); chk("t1_pre_r", r4, 0);
        edges(1);  chk("t1_r1", r4, 1); chk("t1_tick1", t4, 1); chk("t1_wrap1", w4, 0);
        edges(4);  chk("t1_r2", r4, 2);
        edges(4);  chk("t1_r3", r4, 3); chk("t1_wrap3", w4, 0);
        edges(4);  chk("t1_r0", r4, 0); chk("t1_wrap0", w4, 1); chk("t1_tick0", t4, 1);
        chk("t1_an_tick", an4, BLK_ON ? 0 : 1);
        edges(1);  chk("t1_an_tick1", an4, BLK_ON ? 0 : 1); chk("t1_tick_off", t4, 0);
        edges(1);  chk("t1_an_after", an4, 1);

        // Down scan on the 3-digit instance, PRESCALE=5.
        do_reset();
        up = 1'b0; en = 1'b1;
        edges(5);  chk("t2_r2", r3, 2); chk("t2_wrap", w3, 1); chk("t2_tick", t3, 1);
        edges(2);  chk("t2_an100", an3, 3'b100);
        edges(3);  chk("t2_r1", r3, 1); chk("t2_nowrap1", w3, 0);
        edges(5);  chk("t2_r0", r3, 0); chk("t2_nowrap0", w3, 0);
        edges(2);  chk("t2_an001", an3, 3'b001);

        // Pause at prescaler=2, resume two cycles before the step.
        do_reset();
        en = 1'b1;
        edges(2);  en = 1'b0;
        edges(10); chk("t3_hold_r", r4, 0); chk("t3_hold_tick", t4, 0);
        en = 1'b1;
        edges(1);  chk("t3_tick_early", t4, 0);
        edges(1);  chk("t3_tick", t4, 1); chk("t3_r", r4, 1);

        // Clear coincident with a step.
        do_reset();
        en = 1'b1;
        edges(3);  clr = 1'b1;
        edges(1);  chk("t4_r", r4, 0); chk("t4_tick", t4, 0); chk("t4_an", an4, 1);
        clr = 1'b0;
        edges(3);  chk("t4_tick_early", t4, 0);
        edges(1);  chk("t4_tick", t4, 1); chk("t4_r1", r4, 1);

        // Asynchronous reset mid-period, checked before any clock edge.
        do_reset();
        en = 1'b1;
        edges(6);
        rst_n = 1'b0;
        #1;
        chk("t5_r", r4, 0); chk("t5_an", an4, 1); chk("t5_tick", t4, 0); chk("t5_wrap", w4, 0);
        edges(1);
        rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            edges(1);
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) up = ~up;
            clr = ($urandom_range(0, 99) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
        end
        rst_n = 1'b1;
        edges(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
